// File: rtl/ex_alu_unit_if.sv
// ex_alu_unit_if: bundles the operation handshake and result bus of the EX-stage ALU.
//   master : upstream/downstream side (decoder, hazard unit, EX/MEM register)
//            drives in_valid, ALUControl, SrcA, SrcB, stall_in, flush;
//            observes out_valid, ALUResult, Zero, busy.
//   slave  : the ALU itself (ex_alu_unit).
interface ex_alu_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             in_valid;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             stall_in;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             busy;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, stall_in, flush,
        input  out_valid, ALUResult, Zero, busy
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, stall_in, flush,
        output out_valid, ALUResult, Zero, busy
    );
endinterface

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU with a registered result/Zero pair.
// add/sub/and/or/xor/slt finish in one clock; sll/srl run on a serial
// 1-bit-per-cycle shifter, during which busy stalls the upstream pipeline.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   alu_if : slave side of ex_alu_unit_if (operation in, result out, busy)
module ex_alu_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input logic          clk,
    input logic          rst_n,
    ex_alu_unit_if.slave alu_if
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpSlt = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;  // 1: logical right, 0: left
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             busy;
    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] shifted;
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;

    assign busy     = (state_q != StIdle);
    assign accept   = alu_if.in_valid & ~busy & ~alu_if.stall_in & ~alu_if.flush;
    assign is_shift = (alu_if.ALUControl[2:1] == 2'b11);
    assign shamt    = alu_if.SrcB[SHW-1:0];
    assign shifted  = dir_q ? (shreg_q >> 1) : (shreg_q << 1);

    // Single-cycle datapath; shift codes only reach here with a zero count,
    // in which case the result is SrcA unchanged.
    always_comb begin
        alu_val = alu_if.SrcA;
        case (alu_if.ALUControl)
            OpAdd:   alu_val = alu_if.SrcA + alu_if.SrcB;
            OpSub:   alu_val = alu_if.SrcA - alu_if.SrcB;
            OpAnd:   alu_val = alu_if.SrcA & alu_if.SrcB;
            OpOr:    alu_val = alu_if.SrcA | alu_if.SrcB;
            OpXor:   alu_val = alu_if.SrcA ^ alu_if.SrcB;
            OpSlt:   alu_val = {{(WIDTH-1){1'b0}},
                                ($signed(alu_if.SrcA) < $signed(alu_if.SrcB))};
            default: alu_val = alu_if.SrcA;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q;
        wr_en       = 1'b0;
        wr_val      = shreg_q;

        if (alu_if.flush) begin
            // Result value left as is; only its valid flag is dropped.
            state_d     = StIdle;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (is_shift) begin
                            shreg_d = alu_if.SrcA;
                            cnt_d   = shamt;
                            dir_d   = alu_if.ALUControl[0];
                            if (shamt == '0) begin
                                wr_en       = 1'b1;
                                wr_val      = alu_val;
                                out_valid_d = 1'b1;
                            end else begin
                                state_d     = StShift;
                                out_valid_d = 1'b0;
                            end
                        end else begin
                            wr_en       = 1'b1;
                            wr_val      = alu_val;
                            out_valid_d = 1'b1;
                        end
                    end else if (!alu_if.stall_in) begin
                        out_valid_d = 1'b0;
                    end
                end

                StShift: begin
                    // The shifter keeps running under stall; only the write-out waits.
                    shreg_d = shifted;
                    cnt_d   = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        if (!alu_if.stall_in) begin
                            wr_en       = 1'b1;
                            wr_val      = shifted;
                            out_valid_d = 1'b1;
                            state_d     = StIdle;
                        end else begin
                            state_d = StHold;
                        end
                    end
                end

                StHold: begin
                    if (!alu_if.stall_in) begin
                        wr_en       = 1'b1;
                        wr_val      = shreg_q;
                        out_valid_d = 1'b1;
                        state_d     = StIdle;
                    end
                end

                default: state_d = StIdle;
            endcase
        end

        result_d = wr_en ? wr_val : result_q;
        zero_d   = wr_en ? (wr_val == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign alu_if.out_valid = out_valid_q;
    assign alu_if.ALUResult = result_q;
    assign alu_if.Zero      = zero_q;
    assign alu_if.busy      = busy;

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: self-checking bench for ex_alu_unit. Expected values come from
// a plain-arithmetic reference function and from counting cycles against the
// stall pattern the bench itself applies.
module tb_ex_alu_unit;
    localparam int unsigned W = 32;
    localparam int unsigned S = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_alu_unit_if #(.WIDTH(W), .SHW(S)) bus ();

    ex_alu_unit #(.WIDTH(W), .SHW(S)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_if (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        int n;
        logic [31:0] r;
        n = int'(b % 32);
        case (code)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    r = a << n;
            default: r = a >> n;
        endcase
        return r;
    endfunction

    task automatic drive(input logic v, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic st, input logic fl);
        bus.in_valid   = v;
        bus.ALUControl = code;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.stall_in   = st;
        bus.flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        tick();
        tick();
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.ALUResult !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.ALUResult); end
        checks++;
        if (bus.Zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", bus.Zero); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        rst_n = 1'b1;
        tick();
        if (bus.out_valid !== 1'b0 || bus.ALUResult !== 32'd0 || bus.Zero !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b result=%h zero=%b want 0/0/1",
                     bus.out_valid, bus.ALUResult, bus.Zero);
        end
        checks++;
    endtask

    task automatic test_directed();
        logic [2:0]  codes [8] = '{3'd0, 3'd1, 3'd5, 3'd5, 3'd0, 3'd2, 3'd3, 3'd4};
        logic [31:0] as    [8] = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                                   32'hF0F0, 32'hF0F0, 32'hF0F0};
        logic [31:0] bs    [8] = '{32'd7, 32'd3, 32'd1, 32'h8000_0000, 32'd1,
                                   32'hFF00, 32'hFF00, 32'hFF00};
        logic [31:0] exps  [8] = '{32'd12, 32'd0, 32'd1, 32'd0, 32'd0,
                                   32'hF000, 32'hFFF0, 32'h0FF0};
        // Issued on consecutive cycles: each result must appear the very next cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, codes[i], as[i], bs[i], 1'b0, 1'b0);
            tick();
            if (bus.ALUResult !== exps[i] || bus.Zero !== (exps[i] == 32'd0) || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d]: result=%h zero=%b valid=%b want %h/%b/1",
                         i, bus.ALUResult, bus.Zero, bus.out_valid, exps[i], exps[i] == 32'd0);
            end
            checks++;
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL directed_idle_valid: got %b want 0", bus.out_valid); end
        checks++;
    endtask

    task automatic test_random_single();
        logic        v;
        logic [2:0]  code;
        logic [31:0] a, b, exp;
        for (int i = 0; i < 60; i++) begin
            v    = ($urandom_range(0, 4) != 0);
            code = 3'($urandom_range(0, 5));
            a    = $urandom();
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom();
            drive(v, code, a, b, 1'b0, 1'b0);
            tick();
            if (v) begin
                exp = ref_alu(code, a, b);
                if (bus.out_valid !== 1'b1 || bus.ALUResult !== exp || bus.Zero !== (exp == 32'd0)) begin
                    errors++;
                    $display("FAIL random_op[%0d] code=%0d: result=%h zero=%b valid=%b want %h/%b/1",
                             i, code, bus.ALUResult, bus.Zero, bus.out_valid, exp, exp == 32'd0);
                end
            end else begin
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL random_bubble[%0d]: valid got %b want 0", i, bus.out_valid);
                end
            end
            checks++;
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
    endtask

    // Unstalled serial shift; junk ops are offered on every cycle busy is expected high.
    task automatic test_shift(input logic [2:0] code, input logic [31:0] a, input int n);
        logic [31:0] b, exp;
        int k, busy_cnt;
        logic done;
        b = ($urandom() & ~32'h1F) | 32'(n);
        exp = ref_alu(code, a, b);
        drive(1'b1, code, a, b, 1'b0, 1'b0);
        tick();
        k = 1;
        busy_cnt = 0;
        done = 1'b0;
        while (k <= 40) begin
            if (bus.out_valid === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (k <= n) drive(1'b1, 3'($urandom_range(0, 7)), $urandom(), $urandom(), 1'b0, 1'b0);
            else        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
            k++;
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        if (!done) begin errors++; $display("FAIL shift_timeout code=%0d n=%0d: no out_valid in 40 cycles", code, n); end
        checks++;
        if (done && k != n + 1) begin errors++; $display("FAIL shift_latency code=%0d n=%0d: got %0d want %0d", code, n, k, n + 1); end
        checks++;
        if (busy_cnt != n) begin errors++; $display("FAIL shift_busy_cycles code=%0d n=%0d: got %0d want %0d", code, n, busy_cnt, n); end
        checks++;
        if (bus.ALUResult !== exp || bus.Zero !== (exp == 32'd0) || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL shift_result code=%0d a=%h n=%0d: result=%h zero=%b busy=%b want %h/%b/0",
                     code, a, n, bus.ALUResult, bus.Zero, bus.busy, exp, exp == 32'd0);
        end
        checks++;
        tick();
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL shift_after code=%0d n=%0d: valid=%b busy=%b want 0/0", code, n, bus.out_valid, bus.busy);
        end
        checks++;
    endtask

    // Serial shift under a stall pattern; mask bit k = stall_in during cycle k.
    task automatic test_stall_shift(input logic [2:0] code, input logic [31:0] a, input int n,
                                    input logic [63:0] mask);
        logic [31:0] b, exp;
        int cstar;
        b = 32'(n);
        exp = ref_alu(code, a, b);
        // Completion: first unstalled cycle at or after n.
        cstar = n;
        while (cstar < 62 && mask[cstar]) cstar++;
        drive(1'b1, code, a, b, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= cstar + 1; k++) begin
            if (bus.busy !== (k <= cstar) || bus.out_valid !== (k == cstar + 1)) begin
                errors++;
                $display("FAIL stall_shift n=%0d cycle %0d: busy=%b valid=%b want %b/%b",
                         n, k, bus.busy, bus.out_valid, k <= cstar, k == cstar + 1);
            end
            checks++;
            if (k == cstar + 1) begin
                if (bus.ALUResult !== exp) begin
                    errors++;
                    $display("FAIL stall_shift_result n=%0d: got %h want %h", n, bus.ALUResult, exp);
                end
                checks++;
            end
            if (k <= cstar) drive(1'b1, 3'($urandom_range(0, 7)), $urandom(), $urandom(), mask[k], 1'b0);
            else            drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            tick();
        end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_shift_clear n=%0d: valid got %b want 0", n, bus.out_valid); end
        checks++;
    endtask

    task automatic test_stall_single();
        logic [31:0] a, b, exp;
        a = $urandom() | 32'h1;
        b = $urandom() & 32'h7FFF_FFFF;
        exp = a + b;
        drive(1'b1, 3'd0, a, b, 1'b0, 1'b0);
        tick();
        if (bus.out_valid !== 1'b1 || bus.ALUResult !== exp) begin
            errors++;
            $display("FAIL stall_single_issue: result=%h valid=%b want %h/1", bus.ALUResult, bus.out_valid, exp);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd1, $urandom(), $urandom(), 1'b1, 1'b0);
            tick();
            if (bus.out_valid !== 1'b1 || bus.ALUResult !== exp || bus.Zero !== (exp == 32'd0)) begin
                errors++;
                $display("FAIL stall_frozen[%0d]: result=%h valid=%b want %h/1", i, bus.ALUResult, bus.out_valid, exp);
            end
            checks++;
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        if (bus.out_valid !== 1'b0 || bus.ALUResult !== exp) begin
            errors++;
            $display("FAIL stall_release: result=%h valid=%b want %h/0", bus.ALUResult, bus.out_valid, exp);
        end
        checks++;
    endtask

    task automatic test_flush();
        logic [31:0] a;
        a = $urandom() | 32'h1;
        drive(1'b1, 3'd6, a, 32'd10, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b want 1", bus.busy); end
        checks++;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_shift: busy=%b valid=%b want 0/0", bus.busy, bus.out_valid);
        end
        checks++;
        drive(1'b1, 3'd0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        if (bus.ALUResult !== 32'd12 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_next_add: result=%h valid=%b want 0000000c/1", bus.ALUResult, bus.out_valid);
        end
        checks++;
        // Flush together with an offered op: op dropped, valid cleared.
        drive(1'b1, 3'd0, 32'd9, 32'd9, 1'b0, 1'b1);
        tick();
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drops_op: valid got %b want 0", bus.out_valid); end
        checks++;
        // Flush together with stall mid-shift: flush wins.
        drive(1'b1, 3'd7, a, 32'd20, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        tick();
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_stall: busy=%b valid=%b want 0/0", bus.busy, bus.out_valid);
        end
        checks++;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'd0, 32'h1234, 32'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd6, 32'hABCD, 32'd20, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        if (bus.busy !== 1'b1 || bus.ALUResult !== 32'h1235) begin
            errors++;
            $display("FAIL async_pre: busy=%b result=%h want 1/00001235", bus.busy, bus.ALUResult);
        end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.ALUResult !== 32'd0 || bus.Zero !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b result=%h zero=%b want 0/0/0/1",
                     bus.busy, bus.out_valid, bus.ALUResult, bus.Zero);
        end
        checks++;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 3'd0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        if (bus.ALUResult !== 32'd12 || bus.out_valid !== 1'b1 || bus.Zero !== 1'b0) begin
            errors++;
            $display("FAIL async_recover: result=%h valid=%b zero=%b want 0000000c/1/0",
                     bus.ALUResult, bus.out_valid, bus.Zero);
        end
        checks++;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        logic [63:0] m;
        int n;
        test_reset();
        test_directed();
        test_random_single();
        test_shift(3'd6, 32'h1, 31);
        test_shift(3'd7, 32'h8000_0000, 4);
        test_shift(3'd6, $urandom(), 0);
        test_shift(3'd7, $urandom(), 0);
        for (int i = 0; i < 6; i++) begin
            test_shift(3'($urandom_range(6, 7)), $urandom(), int'($urandom_range(1, 31)));
        end
        test_stall_shift(3'd7, $urandom(), 3, 64'h7C);
        for (int i = 0; i < 5; i++) begin
            n = int'($urandom_range(1, 12));
            m = 64'($urandom()) & ((64'd1 << (n + 6)) - 64'd1) & ~64'd1;
            test_stall_shift(3'($urandom_range(6, 7)), $urandom(), n, m);
        end
        test_stall_single();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
